// File: rtl/adc_capture_seq_if.sv
// ADC capture sequencer bundle: control/config inputs, ADC req/ack port,
// raw-register write port and status outputs. master = sequencer side.
interface adc_capture_seq_if #(
  parameter int SAMPLE_W = 24
);
  logic                ctrl_enable;
  logic                ctrl_start;
  logic                snapshot_req;
  logic [3:0]          cfg_num_ch;
  logic                err_clr;
  logic                adc_req;
  logic [2:0]          adc_ch;
  logic                adc_ack;
  logic [SAMPLE_W-1:0] adc_data;
  logic                raw_we;
  logic [2:0]          raw_idx;
  logic [31:0]         raw_data;
  logic                busy;
  logic                done;
  logic                err_timeout;
  logic [15:0]         frame_cnt;

  modport master (
    input  ctrl_enable, ctrl_start, snapshot_req,
    input  cfg_num_ch, err_clr, adc_ack, adc_data,
    output adc_req, adc_ch, raw_we, raw_idx, raw_data,
    output busy, done, err_timeout, frame_cnt
  );

  modport slave (
    output ctrl_enable, ctrl_start, snapshot_req,
    output cfg_num_ch, err_clr, adc_ack, adc_data,
    input  adc_req, adc_ch, raw_we, raw_idx, raw_data,
    input  busy, done, err_timeout, frame_cnt
  );
endinterface

// File: rtl/adc_capture_seq.sv
// ADC frame sequencer: per trigger, requests channels 0..N-1, writes each
// sign-extended sample to ADC_RAW, reports busy/done/timeout/frame count.
// Ports: wb_clk_i, wb_rst_n_i (async, active low), bus (master modport).
module adc_capture_seq #(
  parameter int MAX_CH      = 8,
  parameter int SAMPLE_W    = 24,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_n_i,
  adc_capture_seq_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    STORE,
    DONE
  } state_t;

  localparam logic [3:0]  MAX_N   = 4'(MAX_CH);
  localparam logic [15:0] TMO_LIM = 16'(TIMEOUT_CYC - 1);

  state_t                     state, state_nxt;
  logic [2:0]                 ch, ch_nxt;
  logic [2:0]                 nlast, nlast_nxt;
  logic [2:0]                 nlast_cfg;
  logic                       pending, pend_nxt;
  logic [15:0]                tmo_cnt, tmo_nxt;
  logic signed [SAMPLE_W-1:0] sample, smp_nxt;
  logic                       err, err_nxt;
  logic [15:0]                fcnt, fcnt_nxt;
  logic                       trig;

  assign trig = (bus.ctrl_start | bus.snapshot_req)
              & bus.ctrl_enable;

  // Last channel index of a frame, clamped to 0..MAX_CH-1
  always_comb begin
    nlast_cfg = 3'd0;
    if (bus.cfg_num_ch == 4'd0)
      nlast_cfg = 3'd0;
    else if (bus.cfg_num_ch > MAX_N)
      nlast_cfg = 3'(MAX_N - 4'd1);
    else
      nlast_cfg = 3'(bus.cfg_num_ch - 4'd1);
  end

  always_comb begin
    state_nxt = state;
    ch_nxt    = ch;
    nlast_nxt = nlast;
    pend_nxt  = pending;
    tmo_nxt   = tmo_cnt;
    smp_nxt   = sample;
    fcnt_nxt  = fcnt;
    err_nxt   = err & ~bus.err_clr;
    unique case (state)
      IDLE: begin
        tmo_nxt  = '0;
        pend_nxt = 1'b0;
        if (trig || (pending && bus.ctrl_enable)) begin
          state_nxt = REQ;
          ch_nxt    = 3'd0;
          nlast_nxt = nlast_cfg;
        end
      end
      REQ: begin
        if (trig)
          pend_nxt = 1'b1;
        // An ack in the final timeout cycle still counts
        if (bus.adc_ack) begin
          smp_nxt   = bus.adc_data;
          state_nxt = STORE;
        end else if (tmo_cnt == TMO_LIM) begin
          state_nxt = IDLE;
          err_nxt   = 1'b1;
          pend_nxt  = 1'b0;
          tmo_nxt   = '0;
        end else begin
          tmo_nxt = tmo_cnt + 16'd1;
        end
      end
      STORE: begin
        tmo_nxt = '0;
        if (trig)
          pend_nxt = 1'b1;
        if (ch < nlast) begin
          ch_nxt    = ch + 3'd1;
          state_nxt = REQ;
        end else begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        fcnt_nxt = fcnt + 16'd1;
        pend_nxt = trig;
        if (pending) begin
          state_nxt = REQ;
          ch_nxt    = 3'd0;
          nlast_nxt = nlast_cfg;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Enable drop aborts any frame without error or done
    if (state != IDLE && !bus.ctrl_enable) begin
      state_nxt = IDLE;
      pend_nxt  = 1'b0;
      tmo_nxt   = '0;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state   <= IDLE;
      ch      <= '0;
      nlast   <= '0;
      pending <= 1'b0;
      tmo_cnt <= '0;
      sample  <= '0;
      err     <= 1'b0;
      fcnt    <= '0;
    end else begin
      state   <= state_nxt;
      ch      <= ch_nxt;
      nlast   <= nlast_nxt;
      pending <= pend_nxt;
      tmo_cnt <= tmo_nxt;
      sample  <= smp_nxt;
      err     <= err_nxt;
      fcnt    <= fcnt_nxt;
    end
  end

  assign bus.adc_req     = (state == REQ);
  assign bus.adc_ch      = ch;
  assign bus.raw_we      = (state == STORE);
  assign bus.raw_idx     = ch;
  // Signed size cast sign-extends the sample
  assign bus.raw_data    = 32'(sample);
  assign bus.busy        = (state != IDLE);
  assign bus.done        = (state == DONE);
  assign bus.err_timeout = err;
  assign bus.frame_cnt   = fcnt;

endmodule

// File: tb/tb_adc_capture_seq.sv
// Self-checking bench for adc_capture_seq: vector table of frames,
// scoreboard on raw writes, plus timeout/pending/enable/reset sequences.
module tb_adc_capture_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  adc_capture_seq_if #(.SAMPLE_W(24)) bus();

  adc_capture_seq #(
    .MAX_CH(8),
    .SAMPLE_W(24),
    .TIMEOUT_CYC(16)
  ) dut (
    .wb_clk_i(clk),
    .wb_rst_n_i(rst_n),
    .bus(bus.master)
  );

  typedef struct {
    logic [2:0]  idx;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [3:0]  cfg;
    logic [23:0] base;
    int          exp_n;
  } vec_t;

  wr_t  sb_q[$];
  vec_t vecs[5];

  int checks = 0;
  int failures = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int cyc = 0;
  int last_done_cyc = 0;
  int done_gap = 0;
  logic last_we = 1'b0;

  logic        ack_en = 1'b1;
  logic [23:0] ack_base = '0;
  int          ack_wait = 0;

  function automatic void chk(string nm,
                              logic [31:0] act,
                              logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endfunction

  function automatic logic [31:0] sext(logic [23:0] s);
    return {{8{s[23]}}, s};
  endfunction

  task automatic push_frame(int n, logic [23:0] base);
    wr_t w;
    for (int c = 0; c < n; c++) begin
      logic [23:0] s;
      s = base + 24'(c);
      w.idx  = 3'(c);
      w.data = sext(s);
      sb_q.push_back(w);
    end
  endtask

  // Front-end model: ack two cycles after req with base+ch
  always @(negedge clk) begin
    if (!rst_n) begin
      bus.adc_ack <= 1'b0;
      ack_wait = 0;
    end else if (bus.adc_ack) begin
      bus.adc_ack <= 1'b0;
      ack_wait = 0;
    end else if (bus.adc_req && ack_en) begin
      ack_wait++;
      if (ack_wait >= 2) begin
        bus.adc_ack  <= 1'b1;
        bus.adc_data <= ack_base + 24'(bus.adc_ch);
      end
    end
  end

  // Write/done monitor and scoreboard
  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (bus.raw_we) begin
        wr_cnt++;
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexp_we idx=%0d data=%h",
                   bus.raw_idx, bus.raw_data);
        end else begin
          wr_t e;
          e = sb_q.pop_front();
          chk("raw_idx", 32'(bus.raw_idx), 32'(e.idx));
          chk("raw_data", bus.raw_data, e.data);
        end
      end
      if (bus.done) begin
        done_cnt++;
        done_gap = cyc - last_done_cyc;
        last_done_cyc = cyc;
        chk("done_after_we", 32'(last_we), 32'd1);
      end
      last_we = bus.raw_we;
    end else begin
      last_we = 1'b0;
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    bus.ctrl_start = 1'b1;
    @(negedge clk);
    bus.ctrl_start = 1'b0;
  endtask

  task automatic pulse_snap();
    @(negedge clk);
    bus.snapshot_req = 1'b1;
    @(negedge clk);
    bus.snapshot_req = 1'b0;
  endtask

  task automatic wait_dones(int target, int budget);
    for (int i = 0; i < budget; i++) begin
      if (done_cnt >= target) break;
      @(negedge clk);
    end
    chk("done_wait", 32'(done_cnt), 32'(target));
  endtask

  int fexp = 0;
  int d0, w0, n;
  logic found, any_act;

  initial begin
    vecs[0] = '{cfg: 4'd4,  base: 24'h800001, exp_n: 4};
    vecs[1] = '{cfg: 4'd0,  base: 24'h123456, exp_n: 1};
    vecs[2] = '{cfg: 4'd12, base: 24'h000010, exp_n: 8};
    vecs[3] = '{cfg: 4'd1,  base: 24'h7FFFFF, exp_n: 1};
    vecs[4] = '{cfg: 4'd8,  base: 24'hFFFFF0, exp_n: 8};

    bus.ctrl_enable  = 1'b1;
    bus.ctrl_start   = 1'b0;
    bus.snapshot_req = 1'b0;
    bus.cfg_num_ch   = 4'd4;
    bus.err_clr      = 1'b0;
    bus.adc_data     = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_req", 32'(bus.adc_req), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_we", 32'(bus.raw_we), 32'd0);
    chk("rst_data", bus.raw_data, 32'd0);
    chk("rst_err", 32'(bus.err_timeout), 32'd0);
    chk("rst_fcnt", 32'(bus.frame_cnt), 32'd0);
    rst_n = 1'b1;

    // Async reset mid-frame
    pulse_start();
    chk("pre_rst_req", 32'(bus.adc_req), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_req", 32'(bus.adc_req), 32'd0);
    chk("async_rst_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Table of frames
    for (int v = 0; v < 5; v++) begin
      ack_base       = vecs[v].base;
      bus.cfg_num_ch = vecs[v].cfg;
      w0 = wr_cnt;
      d0 = done_cnt;
      push_frame(vecs[v].exp_n, vecs[v].base);
      fexp++;
      pulse_start();
      wait_dones(d0 + 1, 300);
      @(negedge clk);
      chk("vec_writes", 32'(wr_cnt - w0), 32'(vecs[v].exp_n));
      chk("vec_fcnt", 32'(bus.frame_cnt), 32'(fexp));
      chk("vec_sb_empty", 32'(sb_q.size()), 32'd0);
      chk("vec_busy_low", 32'(bus.busy), 32'd0);
    end

    // Pending: extra triggers during a frame give one more frame
    ack_base       = 24'h000100;
    bus.cfg_num_ch = 4'd2;
    d0 = done_cnt;
    push_frame(2, ack_base);
    push_frame(2, ack_base);
    pulse_start();
    pulse_snap();
    pulse_snap();
    pulse_start();
    wait_dones(d0 + 2, 300);
    fexp += 2;
    repeat (30) @(negedge clk);
    chk("pend_dones", 32'(done_cnt - d0), 32'd2);
    chk("pend_gap", 32'(done_gap), 32'd7);
    chk("pend_fcnt", 32'(bus.frame_cnt), 32'(fexp));
    chk("pend_sb_empty", 32'(sb_q.size()), 32'd0);

    // Timeout with no acks
    ack_en         = 1'b0;
    bus.cfg_num_ch = 4'd1;
    d0 = done_cnt;
    pulse_start();
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus.adc_req) n++;
      else if (n > 0) break;
      @(negedge clk);
    end
    chk("tmo_req_cycles", 32'(n), 32'd16);
    chk("tmo_err", 32'(bus.err_timeout), 32'd1);
    chk("tmo_busy", 32'(bus.busy), 32'd0);
    chk("tmo_fcnt", 32'(bus.frame_cnt), 32'(fexp));
    chk("tmo_no_done", 32'(done_cnt), 32'(d0));
    @(negedge clk);
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    chk("err_clr", 32'(bus.err_timeout), 32'd0);
    ack_en = 1'b1;

    // Enable drop during channel 2 request
    ack_base       = 24'h000200;
    bus.cfg_num_ch = 4'd4;
    d0 = done_cnt;
    w0 = wr_cnt;
    push_frame(2, ack_base);
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (bus.adc_req && bus.adc_ch == 3'd2) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("en_ch2_seen", 32'(found), 32'd1);
    bus.ctrl_enable = 1'b0;
    @(negedge clk);
    chk("en_req_low", 32'(bus.adc_req), 32'd0);
    chk("en_busy_low", 32'(bus.busy), 32'd0);
    repeat (20) @(negedge clk);
    chk("en_no_done", 32'(done_cnt), 32'(d0));
    chk("en_writes", 32'(wr_cnt - w0), 32'd2);
    chk("en_sb_empty", 32'(sb_q.size()), 32'd0);
    chk("en_no_err", 32'(bus.err_timeout), 32'd0);

    // Start while disabled does nothing
    any_act = 1'b0;
    pulse_start();
    for (int i = 0; i < 10; i++) begin
      any_act |= bus.busy | bus.adc_req | bus.raw_we;
      @(negedge clk);
    end
    chk("dis_no_activity", 32'(any_act), 32'd0);
    chk("dis_fcnt", 32'(bus.frame_cnt), 32'(fexp));
    bus.ctrl_enable = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
